// File: rtl/decode_lane_arbiter.sv
// Round-robin arbiter that shares one packet decoder between NUM_LANES lane FIFOs.
// Optional watchdog in DECODE is compiled in with `define DECODE_TIMEOUT_EN.
module decode_lane_arbiter #(
  parameter int NUM_LANES      = 4,
  parameter int LANE_W         = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LANES-1:0]         empty_pkt_fifo,
  output logic [NUM_LANES-1:0]         read_pkt_fifo,
  input  logic                         ready_decode_pkt,
  output logic                         start_decode_pkt,
  input  logic                         decode_done,
  output logic [LANE_W-1:0]            lane_sel,
  output logic                         lane_valid,
  output logic                         busy,
  output logic [NUM_LANES*CNT_W-1:0]   lane_pkt_cnt,
  output logic                         decode_timeout
);

  typedef enum logic [1:0] {IDLE, READ, DECODE} state_e;

  state_e                           state_q, state_d;
  logic [LANE_W-1:0]                lane_sel_q, lane_sel_d;
  logic [LANE_W-1:0]                last_grant_q, last_grant_d;
  logic [NUM_LANES-1:0]             req;
  logic                             grant_vld;
  logic [LANE_W-1:0]                grant_idx;
  logic                             to_evt;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt_q;

  assign req = ~empty_pkt_fifo;

  // Scan downward so the closest lane after last_grant is the final assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (req[(int'(last_grant_q) + k) % NUM_LANES]) begin
        grant_vld = 1'b1;
        grant_idx = LANE_W'((int'(last_grant_q) + k) % NUM_LANES);
      end
    end
  end

`ifdef DECODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q;
  logic          to_q;

  // Completion in the final allowed cycle beats the watchdog.
  assign to_evt = (state_q == DECODE) && !decode_done &&
                  (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= to_evt;
      if (state_q == READ)        wd_q <= '0;
      else if (state_q == DECODE) wd_q <= wd_q + 1'b1;
    end
  end

  assign decode_timeout = to_q;
`else
  localparam int unsigned TO_LIM = TIMEOUT_CYCLES;
  logic unused_to;
  assign unused_to      = TO_LIM[0];
  assign to_evt         = 1'b0;
  assign decode_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_sel_q   <= '0;
      last_grant_q <= LANE_W'(NUM_LANES - 1);
    end else begin
      state_q      <= state_d;
      lane_sel_q   <= lane_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_sel_d   = lane_sel_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_vld && ready_decode_pkt) begin
          lane_sel_d = grant_idx;
          state_d    = READ;
        end
      end
      READ: state_d = DECODE;
      DECODE: begin
        if (decode_done || to_evt) begin
          state_d      = IDLE;
          last_grant_d = lane_sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign read_pkt_fifo[i] = (state_q == READ) && (lane_sel_q == LANE_W'(i));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_q[i] <= '0;
        else if ((state_q == DECODE) && decode_done && (lane_sel_q == LANE_W'(i)))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  endgenerate

  assign start_decode_pkt = (state_q == DECODE);
  assign lane_valid       = (state_q != IDLE);
  assign busy             = (state_q != IDLE);
  assign lane_sel         = lane_sel_q;
  assign lane_pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_lane_arbiter.sv
// Directed bench for decode_lane_arbiter: reset, single lane, rotation, ready gating,
// mid-transaction reset and (when DECODE_TIMEOUT_EN is defined) the watchdog.
module tb_decode_lane_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  empty = 4'hF;
  logic [3:0]  rd;
  logic        ready = 1'b1;
  logic        start;
  logic        done = 1'b0;
  logic [1:0]  sel;
  logic        lv, busy, dto;
  logic [63:0] cnt;
  int          total = 0;
  int          bad = 0;

  decode_lane_arbiter #(.NUM_LANES(4), .LANE_W(2), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .empty_pkt_fifo(empty), .read_pkt_fifo(rd),
    .ready_decode_pkt(ready), .start_decode_pkt(start), .decode_done(done),
    .lane_sel(sel), .lane_valid(lv), .busy(busy), .lane_pkt_cnt(cnt),
    .decode_timeout(dto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns cycles until a read strobe is seen; 0 if none within the bound.
  task automatic wait_read(input string tag, output int n);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rd != 4'b0) begin
        n = c;
        break;
      end
    end
    if (n == 0) chk({tag, "_bound"}, 64'd0, 64'd1);
  endtask

  logic [63:0] snap;

  initial begin
    int n, g, last_t;

    // reset state and idle with all FIFOs empty
    tick(); tick();
    chk("rst_out", {54'd0, rd, start, sel, lv, busy, dto}, 64'd0);
    chk("rst_cnt", cnt, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_out", {54'd0, rd, start, sel, lv, busy, dto}, 64'd0);
    end

    // single lane 2, done 5 cycles after start
    empty = 4'b1011;
    wait_read("l2_read", n);
    chk("l2_lat", n, 1);
    chk("l2_rd", rd, 4'b0100);
    chk("l2_sel", sel, 2);
    chk("l2_start0", start, 0);
    chk("l2_lv", lv, 1);
    empty = 4'hF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("l2_start", start, 1);
      chk("l2_rd_once", rd, 4'b0);
      chk("l2_sel_hold", sel, 2);
      if (c == 5) done = 1'b1;
    end
    tick();
    done = 1'b0;
    chk("l2_end_start", start, 0);
    chk("l2_end_busy", busy, 0);
    chk("l2_cnt", cnt, 64'h0000_0001_0000_0000);

    // all lanes requesting: rotation, 3-cycle period
    rst = 1'b1;
    tick();
    chk("rst2_cnt", cnt, 64'd0);
    empty = 4'b0000;
    done  = 1'b1;
    rst   = 1'b0;
    g = 0;
    last_t = 0;
    for (int c = 0; c < 60 && g < 8; c++) begin
      tick();
      if (rd != 4'b0) begin
        chk("rr_rd", rd, 64'(4'b0001 << (g % 4)));
        chk("rr_sel", sel, g % 4);
        if (g > 0) chk("rr_period", c - last_t, 3);
        last_t = c;
        g++;
        if (g == 8) empty = 4'hF;
      end
    end
    chk("rr_count", g, 8);
    tick(); tick();
    chk("rr_busy", busy, 0);
    chk("rr_cnt", cnt, {16'd2, 16'd2, 16'd2, 16'd2});

    // lanes 1 and 3 wait for ready
    empty = 4'b0101;
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("nrdy_rd", rd, 4'b0);
      chk("nrdy_busy", busy, 0);
    end
    ready = 1'b1;
    wait_read("rdy_a", n);
    chk("rdy_a_lat", n, 1);
    chk("rdy_a_sel", sel, 1);
    chk("rdy_a_rd", rd, 4'b0010);
    empty = 4'b0111;
    wait_read("rdy_b", n);
    chk("rdy_b_sel", sel, 3);
    chk("rdy_b_rd", rd, 4'b1000);
    empty = 4'hF;
    tick(); tick();
    chk("rdy_cnt", cnt, {16'd3, 16'd2, 16'd3, 16'd2});

    // lane 0 completes, lane 3 is reset in DECODE, lane 0 wins afterward
    empty = 4'b1110;
    wait_read("pre0", n);
    chk("pre0_sel", sel, 0);
    empty = 4'hF;
    tick(); tick();
    done  = 1'b0;
    empty = 4'b0111;
    wait_read("pre3", n);
    chk("pre3_sel", sel, 3);
    empty = 4'b0110;
    tick();
    chk("pre3_dec", {start, sel}, {1'b1, 2'd3});
    rst = 1'b1;
    #1;
    chk("arst_out", {54'd0, rd, start, sel, lv, busy, dto}, 64'd0);
    @(posedge clk); #1;
    chk("arst_edge_out", {54'd0, rd, start, sel, lv, busy, dto}, 64'd0);
    chk("arst_cnt", cnt, 64'd0);
    tick();
    rst = 1'b0;
    wait_read("post", n);
    chk("post_lat", n, 1);
    chk("post_sel", sel, 0);
    empty = 4'b0111;
    done  = 1'b1;
    wait_read("post3", n);
    chk("post3_sel", sel, 3);
    empty = 4'hF;
    tick(); tick();
    done = 1'b0;
    chk("post_cnt", cnt, 64'h0001_0000_0000_0001);

`ifdef DECODE_TIMEOUT_EN
    // watchdog fires after 16 DECODE cycles without done
    snap  = cnt;
    empty = 4'b1101;
    wait_read("to1", n);
    chk("to1_sel", sel, 1);
    empty = 4'hF;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to1_start", start, 1);
      chk("to1_nopulse", dto, 0);
    end
    tick();
    chk("to1_pulse", dto, 1);
    chk("to1_idle", busy, 0);
    tick();
    chk("to1_pulse_end", dto, 0);
    chk("to1_cnt", cnt, snap);
    empty = 4'b1001;
    wait_read("to2", n);
    chk("to2_sel", sel, 2);
    empty = 4'hF;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to2_start", start, 1);
      if (c == 16) done = 1'b1;
    end
    tick();
    done = 1'b0;
    chk("to2_nopulse", dto, 0);
    chk("to2_idle", busy, 0);
    chk("to2_cnt", cnt, snap + 64'h0000_0001_0000_0000);
`else
    // without the watchdog DECODE waits for done indefinitely
    empty = 4'b1101;
    wait_read("nto", n);
    empty = 4'hF;
    repeat (40) tick();
    chk("nto_start", start, 1);
    chk("nto_dto", dto, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("nto_idle", busy, 0);
    chk("nto_cnt", cnt, 64'h0001_0000_0001_0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time: run did not finish");
    $fatal(1);
  end
endmodule

// File: doc/decode_lane_arbiter.md
Name: decode_lane_arbiter

Overview:
- Shares one packet decode engine between NUM_LANES per-lane packet FIFOs of the 4-lane router.
- Picks a non-empty lane by round-robin, pops one packet from that lane's FIFO, then drives the start/done handshake with the decoder.
- Drives the lane select that steers the chosen FIFO's data into the decoder.
- Sits between the lane packet FIFOs and the single decode_packet datapath. It replaces the per-lane single-FIFO sequencing.

Parameters:
- NUM_LANES, 4, number of requesting lane FIFOs (2..8).
- LANE_W, 2, width of lane index; must equal clog2(NUM_LANES).
- CNT_W, 16, width of each per-lane decoded-packet counter.
- TIMEOUT_CYCLES, 1024, watchdog limit in DECODE (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- empty_pkt_fifo  in  NUM_LANES  per-lane FIFO empty flag; bit i = lane i.
- read_pkt_fifo  out  NUM_LANES  one-hot, one-cycle pop strobe to the granted lane's FIFO.
- ready_decode_pkt  in  1  decoder is idle and can accept a packet.
- start_decode_pkt  out  1  level; high for the whole DECODE state.
- decode_done  in  1  one-cycle pulse from the decoder when the packet is finished.
- lane_sel  out  LANE_W  index of the granted lane; steers the data mux.
- lane_valid  out  1  high in READ and DECODE.
- busy  out  1  high whenever state != IDLE.
- lane_pkt_cnt  out  NUM_LANES*CNT_W  per-lane completed-packet counters; lane i occupies bits [i*CNT_W +: CNT_W].
- decode_timeout  out  1  one-cycle watchdog pulse; tied to 0 when the feature is compiled out.

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE, lane_sel = 0, last_grant = NUM_LANES-1, so lane 0 has first priority.
  - All counters = 0; every output = 0.
- State machine, registered state: IDLE -> READ -> DECODE -> IDLE.
- IDLE:
  - Request vector req = ~empty_pkt_fifo.
  - If req != 0 and ready_decode_pkt = 1: grant the first requesting lane searching upward from last_grant+1, modulo NUM_LANES.
  - On grant, register lane_sel = granted lane and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - read_pkt_fifo[lane_sel] = 1 for exactly one cycle; all other bits 0.
  - Unconditionally go to DECODE.
  - decode_done in this state is ignored.
- DECODE:
  - start_decode_pkt = 1.
  - On decode_done = 1:
    - go to IDLE;
    - last_grant = lane_sel;
    - lane_pkt_cnt[lane_sel] increments by 1, wrapping from 2^CNT_W-1 to 0.
  - A decode_done in the first DECODE cycle is accepted.
- Outputs read_pkt_fifo, start_decode_pkt, lane_valid and busy are Moore outputs, decoded from state only.
- lane_sel is held stable from the grant until the return to IDLE. The FIFO-to-decoder data mux is therefore glitch-free for the whole packet.
- Latency from a lane going non-empty (with the decoder ready) to its read strobe: 1 cycle in IDLE for the grant, then the strobe in the next cycle.
- Minimum turnaround per packet: 3 cycles (IDLE, READ, one DECODE cycle).
- Back-to-back traffic: when DECODE exits, the next grant is evaluated in the following IDLE cycle. There is no IDLE bypass.
- Fairness: with all lanes continuously requesting, grants rotate 0,1,2,3,0,... No lane waits more than NUM_LANES-1 packets.
- Empty flag changes after the grant are not re-checked. This block is the only reader, so a sampled non-empty FIFO stays non-empty.
- ready_decode_pkt deasserting in READ or DECODE has no effect.
- Reset mid-operation aborts the transaction immediately:
  - no read strobe and no start;
  - counters are cleared.

Optional Feature:
- Macro: DECODE_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to DECODE and increments each DECODE cycle.
  - If it reaches TIMEOUT_CYCLES without decode_done:
    - decode_timeout pulses for 1 cycle;
    - state returns to IDLE;
    - last_grant = lane_sel, so the round-robin pointer advances;
    - the lane counter does NOT increment.
  - A decode_done in the same cycle as the timeout wins: normal completion, no pulse.
- Undefined: no watchdog logic; decode_timeout is constant 0; DECODE waits indefinitely.

Test Plan:
- Reset release, empty_pkt_fifo=4'b1111, ready=1 -> stays IDLE 20 cycles; all outputs 0; busy=0.
- Only lane 2 non-empty, ready=1, decode_done 5 cycles after start rises:
  - read_pkt_fifo=4'b0100 for exactly 1 cycle, with lane_sel=2;
  - start high 5 cycles;
  - lane_pkt_cnt lane 2 = 1;
  - return to IDLE.
- All four lanes non-empty, 8 packets, done after 1 DECODE cycle each -> grant order 0,1,2,3,0,1,2,3; each counter = 2; 3-cycle period per packet.
- Lanes 1 and 3 requesting, ready=0 for 10 cycles, then 1 -> no read strobe while ready=0; first grant lane 1, then lane 3.
- Assert rst in DECODE with lane_sel=3 -> next edge: all outputs 0, counters 0; after release, lane 0 has priority over lane 3.
- DECODE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, decode_done never arrives:
  - decode_timeout pulses exactly 16 cycles after DECODE entry;
  - counter unchanged;
  - next request is granted to the next lane.
  - Repeat with done on cycle 16: normal completion, no pulse.
